// File: rtl/key_debounce.sv
// Push-button conditioner for the 10 MHz domain: 2-flop synchroniser, debounce FSM,
// registered press/release strobes and a wrapping press counter. Long-press strobe under KEY_LONG_PRESS_EN.
module key_debounce #(
  parameter int P_DEBOUNCE_CYCLES = 200000,
  parameter int P_LONG_CYCLES     = 10000000,
  parameter bit P_ACTIVE_LOW      = 1'b1,
  parameter int P_CNT_W           = 8
) (
  input  logic               I_10m_clk,
  input  logic               I_rst_n,
  input  logic               I_key_in,
  output logic               O_key_level,
  output logic               O_key_press,
  output logic               O_key_release,
  output logic               O_key_long,
  output logic [P_CNT_W-1:0] O_press_cnt
);

  localparam int                 LP_DB_W   = $clog2(P_DEBOUNCE_CYCLES);
  localparam logic [LP_DB_W-1:0] LP_DB_MAX = LP_DB_W'(P_DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } state_t;

  state_t               S_state, S_state_nxt;
  logic [LP_DB_W-1:0]   S_db_cnt, S_db_cnt_nxt;
  logic                 S_sync1, S_sync2;
  logic                 S_key_act;
  logic                 S_level_nxt, S_press_nxt, S_release_nxt;
  logic [P_CNT_W-1:0]   S_press_cnt_nxt;

  // Synchroniser idles at the released pin level so reset never looks like a press.
  always_ff @(posedge I_10m_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      S_sync1 <= P_ACTIVE_LOW;
      S_sync2 <= P_ACTIVE_LOW;
    end else begin
      S_sync1 <= I_key_in;
      S_sync2 <= S_sync1;
    end
  end

  assign S_key_act = S_sync2 ^ P_ACTIVE_LOW;

  always_ff @(posedge I_10m_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      S_state       <= ST_IDLE;
      S_db_cnt      <= '0;
      O_key_level   <= 1'b0;
      O_key_press   <= 1'b0;
      O_key_release <= 1'b0;
      O_press_cnt   <= '0;
    end else begin
      S_state       <= S_state_nxt;
      S_db_cnt      <= S_db_cnt_nxt;
      O_key_level   <= S_level_nxt;
      O_key_press   <= S_press_nxt;
      O_key_release <= S_release_nxt;
      O_press_cnt   <= S_press_cnt_nxt;
    end
  end

  always_comb begin
    S_state_nxt     = S_state;
    S_db_cnt_nxt    = S_db_cnt;
    S_level_nxt     = O_key_level;
    S_press_nxt     = 1'b0;
    S_release_nxt   = 1'b0;
    S_press_cnt_nxt = O_press_cnt;
    case (S_state)
      ST_IDLE: begin
        if (S_key_act) begin
          S_state_nxt  = ST_PRESS_WAIT;
          S_db_cnt_nxt = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!S_key_act) begin
          S_state_nxt = ST_IDLE;
        end else if (S_db_cnt == LP_DB_MAX) begin
          S_state_nxt     = ST_PRESSED;
          S_level_nxt     = 1'b1;
          S_press_nxt     = 1'b1;
          S_press_cnt_nxt = O_press_cnt + P_CNT_W'(1);
        end else begin
          S_db_cnt_nxt = S_db_cnt + LP_DB_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!S_key_act) begin
          S_state_nxt  = ST_RELEASE_WAIT;
          S_db_cnt_nxt = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        // A bounce back to pressed keeps the level high and never re-counts the press.
        if (S_key_act) begin
          S_state_nxt = ST_PRESSED;
        end else if (S_db_cnt == LP_DB_MAX) begin
          S_state_nxt   = ST_IDLE;
          S_level_nxt   = 1'b0;
          S_release_nxt = 1'b1;
        end else begin
          S_db_cnt_nxt = S_db_cnt + LP_DB_W'(1);
        end
      end
      default: S_state_nxt = ST_IDLE;
    endcase
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int                   LP_LONG_W   = $clog2(P_LONG_CYCLES);
  localparam logic [LP_LONG_W-1:0] LP_LONG_MAX = LP_LONG_W'(P_LONG_CYCLES - 1);

  logic [LP_LONG_W-1:0] S_long_cnt, S_long_cnt_nxt;
  logic                 S_long_done, S_long_done_nxt;
  logic                 S_long_nxt;

  always_ff @(posedge I_10m_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      S_long_cnt  <= '0;
      S_long_done <= 1'b0;
      O_key_long  <= 1'b0;
    end else begin
      S_long_cnt  <= S_long_cnt_nxt;
      S_long_done <= S_long_done_nxt;
      O_key_long  <= S_long_nxt;
    end
  end

  // Held clear until the press is accepted; the done flag limits each press to one strobe.
  always_comb begin
    S_long_cnt_nxt  = S_long_cnt;
    S_long_done_nxt = S_long_done;
    S_long_nxt      = 1'b0;
    case (S_state)
      ST_IDLE, ST_PRESS_WAIT: begin
        S_long_cnt_nxt  = '0;
        S_long_done_nxt = 1'b0;
      end
      ST_PRESSED, ST_RELEASE_WAIT: begin
        if (S_long_cnt != LP_LONG_MAX) begin
          S_long_cnt_nxt = S_long_cnt + LP_LONG_W'(1);
        end else if (!S_long_done) begin
          S_long_nxt      = 1'b1;
          S_long_done_nxt = 1'b1;
        end
      end
      default: begin
        S_long_cnt_nxt  = '0;
        S_long_done_nxt = 1'b0;
      end
    endcase
  end
`else
  assign O_key_long = 1'b0;
`endif

  a_strobe_exclusive : assert property (@(posedge I_10m_clk) disable iff (!I_rst_n)
    !(O_key_press && O_key_release));

  a_db_cnt_range : assert property (@(posedge I_10m_clk) disable iff (!I_rst_n)
    S_db_cnt <= LP_DB_MAX);

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: drivers push expected strobes (kind, edge, count)
// and a negedge monitor pops and compares them as the DUT produces strobes.
module tb_key_debounce;

  localparam int DB    = 4;
  localparam int LONG  = 20;
  localparam int CW    = 8;
  localparam int W     = 42;
  localparam logic [1:0] EV_PRESS   = 2'd1;
  localparam logic [1:0] EV_RELEASE = 2'd2;
  localparam logic [1:0] EV_LONG    = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key;
  logic          key_level, key_press, key_release, key_long;
  logic [CW-1:0] press_cnt;

  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] exp_cnt;

  key_debounce #(
    .P_DEBOUNCE_CYCLES(DB),
    .P_LONG_CYCLES    (LONG),
    .P_ACTIVE_LOW     (1'b1),
    .P_CNT_W          (CW)
  ) dut (
    .I_10m_clk    (clk),
    .I_rst_n      (rst_n),
    .I_key_in     (key),
    .O_key_level  (key_level),
    .O_key_press  (key_press),
    .O_key_release(key_release),
    .O_key_long   (key_long),
    .O_press_cnt  (press_cnt)
  );

  // clock / edge counter
  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic take_event(input logic [1:0] kind);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check_val("unexpected_strobe_kind", 64'(kind), 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check_val("strobe_kind", 64'(kind), 64'(e[41:40]));
    check_val("strobe_edge", 64'(cyc), 64'(e[39:8]));
    check_val("strobe_cnt", 64'(press_cnt), 64'(e[7:0]));
    if (kind == EV_PRESS)   check_val("level_at_press", 64'(key_level), 64'd1);
    if (kind == EV_RELEASE) check_val("level_at_release", 64'(key_level), 64'd0);
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (key_press && key_release) check_val("strobe_overlap", 64'd1, 64'd0);
      if (key_press)   take_event(EV_PRESS);
      if (key_release) take_event(EV_RELEASE);
      if (key_long)    take_event(EV_LONG);
    end
  end

  // drivers
  task automatic hold_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_pin(input logic val, input int n);
    @(negedge clk);
    key = val;
    hold_cycles(n - 1);
  endtask

  task automatic press_start(output int e0);
    @(negedge clk);
    key = 1'b0;
    e0 = cyc + 1;
    exp_cnt = exp_cnt + CW'(1);
    exp_q.push_back({EV_PRESS, 32'(e0 + DB + 2), exp_cnt});
  endtask

  task automatic release_key(input int n);
    int e0;
    @(negedge clk);
    key = 1'b1;
    e0 = cyc + 1;
    exp_q.push_back({EV_RELEASE, 32'(e0 + DB + 2), exp_cnt});
    hold_cycles(n - 1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    check_val("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_quiet(input string tag, input logic lvl, input logic [CW-1:0] cnt);
    check_val({tag, "_level"}, 64'(key_level), 64'(lvl));
    check_val({tag, "_cnt"}, 64'(press_cnt), 64'(cnt));
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_level"}, 64'(key_level), 64'd0);
    check_val({tag, "_press"}, 64'(key_press), 64'd0);
    check_val({tag, "_release"}, 64'(key_release), 64'd0);
    check_val({tag, "_long"}, 64'(key_long), 64'd0);
    check_val({tag, "_cnt"}, 64'(press_cnt), 64'd0);
  endtask

  initial begin
    int e0;
    rst_n   = 1'b0;
    key     = 1'b1;
    exp_cnt = '0;
    hold_cycles(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    drive_pin(1'b1, 5);

    // clean press and release
    press_start(e0);
    hold_cycles(14);
    release_key(10);
    wait_drain(100);
    check_quiet("clean", 1'b0, 8'd1);

    // glitches of 3 and DB cycles are rejected
    drive_pin(1'b0, 3);
    drive_pin(1'b1, 10);
    check_quiet("glitch3", 1'b0, 8'd1);
    drive_pin(1'b0, DB);
    drive_pin(1'b1, 10);
    check_quiet("glitch4", 1'b0, 8'd1);

    // shortest accepted pulse
    press_start(e0);
    hold_cycles(DB);
    release_key(10);
    wait_drain(100);
    check_quiet("min_pulse", 1'b0, 8'd2);

    // release bounce
    press_start(e0);
    hold_cycles(7);
    drive_pin(1'b1, 2);
    drive_pin(1'b0, 6);
    check_quiet("rel_bounce", 1'b1, 8'd3);
    release_key(10);
    wait_drain(100);

    // long press
    press_start(e0);
`ifdef KEY_LONG_PRESS_EN
    exp_q.push_back({EV_LONG, 32'(e0 + DB + 2 + LONG), exp_cnt});
`endif
    hold_cycles(39);
    release_key(10);
    wait_drain(100);
    check_quiet("long", 1'b0, 8'd4);

    // async reset while held, key stays held afterwards
    press_start(e0);
    hold_cycles(9);
    wait_drain(50);
    check_quiet("pre_reset", 1'b1, 8'd5);
    @(posedge clk);
    #20 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    exp_cnt = '0;
    hold_cycles(2);
    rst_n = 1'b1;
    e0 = cyc + 1;
    exp_cnt = 8'd1;
    exp_q.push_back({EV_PRESS, 32'(e0 + DB + 2), exp_cnt});
    hold_cycles(9);
    release_key(10);
    wait_drain(100);
    check_quiet("post_reset", 1'b0, 8'd1);

    // counter wrap from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    exp_cnt = '0;
    hold_cycles(2);
    rst_n = 1'b1;
    hold_cycles(3);
    for (int i = 0; i < 256; i++) begin
      press_start(e0);
      hold_cycles($urandom_range(5, 10) - 1);
      release_key($urandom_range(5, 10));
      if (i == 254) begin
        wait_drain(100);
        check_val("wrap_255", 64'(press_cnt), 64'd255);
      end
      if (i == 255) begin
        wait_drain(100);
        check_val("wrap_0", 64'(press_cnt), 64'd0);
      end
    end
    wait_drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-side counterpart to the board LED driver: conditions a raw push-button pin for the 10 MHz fabric domain.
- Synchronises and debounces the pin, then publishes a clean level plus single-cycle press and release strobes.
- Keeps a wrapping press counter and can optionally flag long presses.
- Sits between the board key pin and control/status logic, such as LED mode selection.

Parameters:
P_DEBOUNCE_CYCLES, 200000, stable-input cycles required to accept a change (20 ms at 10 MHz); must be >= 2
P_LONG_CYCLES, 10000000, cycles in pressed state before a long-press strobe (1 s); must be > P_DEBOUNCE_CYCLES
P_ACTIVE_LOW, 1, 1: pin reads 0 when pressed; 0: pin reads 1 when pressed
P_CNT_W, 8, width of press counter

Ports:
I_10m_clk  input  1  10 MHz system clock, all logic on rising edge
I_rst_n  input  1  asynchronous active-low reset
I_key_in  input  1  raw, asynchronous, bouncing key pin
O_key_level  output  1  debounced key state, 1 = pressed
O_key_press  output  1  one-cycle strobe on accepted press
O_key_release  output  1  one-cycle strobe on accepted release
O_key_long  output  1  one-cycle strobe on long press (see Optional Feature)
O_press_cnt  output  P_CNT_W  count of accepted presses, wraps

Behaviour:
- Reset (I_rst_n low, asynchronous):
  - all outputs 0; state IDLE; all counters 0.
  - Synchroniser flops load the inactive pin level (1 if P_ACTIVE_LOW, else 0).
- Synchroniser: 2 flops on I_key_in. S_key_act = synchronised value XOR P_ACTIVE_LOW, so 1 = pressed.
- Debounce counter S_db_cnt: width ceil(log2(P_DEBOUNCE_CYCLES)). Never exceeds P_DEBOUNCE_CYCLES-1.
- State machine:
  - IDLE:
    - S_key_act=1 -> PRESS_WAIT, S_db_cnt<=0.
  - PRESS_WAIT:
    - S_key_act=0 -> IDLE, bounce, no strobe.
    - Else if S_db_cnt==P_DEBOUNCE_CYCLES-1 -> PRESSED. Set O_key_level<=1, O_key_press<=1, O_press_cnt<=O_press_cnt+1 (modulo 2^P_CNT_W).
    - Else S_db_cnt++.
  - PRESSED:
    - S_key_act=0 -> RELEASE_WAIT, S_db_cnt<=0.
  - RELEASE_WAIT:
    - S_key_act=1 -> PRESSED, bounce. No strobes; O_key_level stays 1; O_press_cnt unchanged.
    - Else if S_db_cnt==P_DEBOUNCE_CYCLES-1 -> IDLE. Set O_key_level<=0, O_key_release<=1.
    - Else S_db_cnt++.
- Strobes:
  - O_key_press and O_key_release are high for exactly one cycle; default 0 every other cycle.
  - They are never both high in the same cycle.
- Latency:
  - Call the rising edge that first samples a changed pin level edge 0.
  - If the pin then stays stable, the strobe is registered at edge P_DEBOUNCE_CYCLES+2.
  - O_key_level changes on the same edge as the strobe.
- Pin pulses shorter than P_DEBOUNCE_CYCLES+1 cycles (after synchronisation) never produce a strobe.
- Reset mid-operation: everything returns to reset values immediately. A key still held after reset deasserts is treated as a new press (full debounce, new strobe, counter 1).
- Registered-output rule: all outputs come directly from flops; no combinational path from I_key_in.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN
- With the macro defined:
  - Counter S_long_cnt, width ceil(log2(P_LONG_CYCLES)), plus flag S_long_done.
  - Both cleared on the PRESS_WAIT->PRESSED transition.
  - S_long_cnt increments every cycle in PRESSED and RELEASE_WAIT, saturating at P_LONG_CYCLES-1.
  - When S_long_cnt==P_LONG_CYCLES-1 and S_long_done==0: O_key_long<=1 for one cycle and S_long_done<=1. At most one long strobe per accepted press; release bounces do not retrigger it.
  - Counter and flag are cleared in IDLE.
- Without the macro:
  - O_key_long is tied to constant 0.
  - No long counter or flag is synthesised.
  - All other behaviour is identical.

Test Plan:
(all with P_DEBOUNCE_CYCLES=4, P_LONG_CYCLES=20, P_ACTIVE_LOW=1, P_CNT_W=8)
- Clean press: pin 1->0, sampled at edge 0, held 15 cycles -> O_key_press pulses at edge 6 only, O_key_level=1 from edge 6, O_press_cnt=1. Release: pin back to 1 at edge r -> O_key_release pulses at edge r+6, O_key_level=0.
- Glitch: pin low for 3 cycles then high -> no strobes, O_key_level stays 0, O_press_cnt stays 0.
- Release bounce: while pressed, pin high for 2 cycles then low again -> no O_key_release, O_key_level stays 1, O_press_cnt unchanged.
- Long press with KEY_LONG_PRESS_EN: hold 40 cycles -> O_key_press at edge 6, single O_key_long at edge 26, no further long strobes; without the macro O_key_long stays 0 throughout.
- Async reset mid-PRESSED, key still held: pull I_rst_n low between clock edges -> all outputs 0 immediately. After reset releases -> O_key_press again 6 edges after first sampling, O_press_cnt=1.
- Wrap: 256 clean press/release cycles -> O_press_cnt reads 255 after the 255th press and 0 after the 256th.
